branch_predictor: RTL and testbench
===================================

# branch_predictor

Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It feeds the pipeline Controller's `BP_taken` input and the IF-stage predicted-target PC mux. Lookup is combinational on the IF-stage PC. Training happens at the clock edge from resolved EXE-stage branch, JAL and JALR outcomes.

## Interface

**Parameters**
- `memAddrWidth`, default 15: byte-address width of PCs; matches the Controller.
- `ENTRIES`, default 16: number of BTB entries; must be a power of two, at least 2.
- `INDEX_W`, default $clog2(ENTRIES): index width; derived, not overridden.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `IF_pc` in memAddrWidth: PC of the instruction in IF.
- `BP_taken` out 1: predict taken for `IF_pc`.
- `BP_target_pc` out memAddrWidth: predicted target for `IF_pc`; equals `IF_pc+4` when not hit.
- `BP_hit` out 1: valid entry whose tag matches `IF_pc`.
- `EXE_pc` in memAddrWidth: PC of the instruction in EXE.
- `E_En` in 1: EXE holds a BRANCH, JAL or JALR; this is the update request.
- `E_Branch_taken` in 1: resolved direction.
- `EXE_target_pc` in memAddrWidth: resolved target.
- `Stall_MA` in 1: memory-access stall; suppresses update.

## Operation

**Field split**
- index = `pc[INDEX_W+1:2]`.
- tag = `pc[memAddrWidth-1:INDEX_W+2]`.
- `pc[1:0]` is ignored.

**Entry contents**
- valid (1 bit), tag, target (memAddrWidth bits), ctr (2 bits).
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.

**Lookup (combinational)**
- `BP_hit` = valid[idx] & (tag[idx]==IF tag).
- `BP_taken` = `BP_hit` & ctr[idx][1].
- `BP_target_pc` = `BP_hit` ? target[idx] : `IF_pc+4`. The sum is truncated to memAddrWidth, so it wraps.

**Update**
- Enable: upd = `E_En` & ~`Stall_MA`. The stall gate prevents double-training while EXE is frozen.
- Hit on `EXE_pc` and taken: ctr = sat+1 (ST stays ST); target <= `EXE_target_pc`.
- Hit on `EXE_pc` and not taken: ctr = sat-1 (SNT stays SNT); target is unchanged.
- Miss and taken: allocate. valid=1, tag <= EXE tag, target <= `EXE_target_pc`, ctr=WT. Any existing entry at that index is overwritten.
- Miss and not taken: no change.
- upd=0: no state change.

## Timing

**Latency**
- Lookup has zero-cycle latency.
- An update is visible to lookup from the cycle after the edge at which upd=1.

**Same index in the same cycle**
- When IF and EXE address the same index in one cycle, the lookup returns pre-update contents. There is no bypass.

**Reset**
- Asynchronous reset forces every valid=0, ctr=WNT, tag=0, target=0.
- Outputs during and after reset, until the first allocation: `BP_hit`=0, `BP_taken`=0, `BP_target_pc`=`IF_pc+4`.

**Reset in mid-operation**
- Assertion clears all entries immediately, whatever the pending update.
- The first update is accepted at the first rising edge after deassertion.

**Boundary conditions**
- `E_En` with X or unknown direction is not permitted.
- PCs that alias on index evict one another; this is correct but lossy behaviour, not an error.

## Structure

- Shared package/define file:
  - counter encodings SNT/WNT/WT/ST;
  - default `ENTRIES`;
  - helper macros for index and tag extraction.
- `rv32_define` opcodes are not needed here; `E_En` already encodes them.
- One natural sub-module: `sat_counter2`, a 2-bit saturating up/down next-state function instantiated per update path. The storage arrays stay in `branch_predictor`.

## Test plan

1. **Reset.** Assert `rst` mid-run after allocations; sweep `IF_pc` 0x0–0x3C → `BP_hit`=0, `BP_taken`=0, `BP_target_pc`=`IF_pc+4` for every value.
2. **Allocate and hit.** One update with `EXE_pc`=0x0040, taken, target 0x0100. Then `IF_pc`=0x0040 → hit=1, taken=1 (WT), target=0x0100. `IF_pc`=0x0440 (same index, different tag) → hit=0.
3. **Saturation.** Same PC:
   - 3 taken updates → ctr=ST; then 1 not-taken → WT, still predicts taken.
   - 4 further not-taken updates → SNT; a 5th stays SNT, predicts not-taken, and the entry stays valid.
4. **Stall gating.** `E_En`=1, taken, `Stall_MA`=1 held for 5 cycles on a WT entry → ctr unchanged. Releasing the stall for 1 cycle → ctr=ST exactly.
5. **Same-cycle read/write.** `IF_pc`=`EXE_pc`=0x0080, allocate taken → `BP_hit`=0 in that cycle and `BP_hit`=1 the next.
6. **Wrap and retarget.**
   - `IF_pc`=0x7FFC with no entry → `BP_target_pc`=0x0000.
   - Taken hit with a new target 0x0200 on an entry targeting 0x0100 → target=0x0200 next cycle.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared counter encodings and PC field helpers for the BTB
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam int DEFAULT_ENTRIES = 16;

    // Word-aligned PCs: bits [1:0] never take part in index or tag.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned index_w);
        return (pc >> 2) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned index_w);
        return pc >> (index_w + 2);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down next-state function
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic up_i,
    output ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (up_i) begin
            if (ctr_i != ST) ctr_o = ctr_e'(ctr_i + 2'd1);
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_e'(ctr_i - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int memAddrWidth = 15,
    parameter int ENTRIES      = DEFAULT_ENTRIES,
    parameter int INDEX_W      = $clog2(ENTRIES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [memAddrWidth-1:0] IF_pc,
    output logic                    BP_taken,
    output logic [memAddrWidth-1:0] BP_target_pc,
    output logic                    BP_hit,
    input  logic [memAddrWidth-1:0] EXE_pc,
    input  logic                    E_En,
    input  logic                    E_Branch_taken,
    input  logic [memAddrWidth-1:0] EXE_target_pc,
    input  logic                    Stall_MA
);

    localparam int TAG_W = memAddrWidth - INDEX_W - 2;

    logic                    valid_q  [ENTRIES];
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [memAddrWidth-1:0] target_q [ENTRIES];
    ctr_e                    ctr_q    [ENTRIES];

    logic [INDEX_W-1:0]      if_idx, exe_idx;
    logic [TAG_W-1:0]        if_tag, exe_tag;
    logic                    if_hit, exe_hit, upd;
    ctr_e                    ctr_next;

    logic                    wr_en_d;
    ctr_e                    wr_ctr_d;
    logic [memAddrWidth-1:0] wr_target_d;

    assign if_idx  = INDEX_W'(pc_index(32'(IF_pc), INDEX_W));
    assign if_tag  = TAG_W'(pc_tag(32'(IF_pc), INDEX_W));
    assign exe_idx = INDEX_W'(pc_index(32'(EXE_pc), INDEX_W));
    assign exe_tag = TAG_W'(pc_tag(32'(EXE_pc), INDEX_W));

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign BP_hit       = if_hit;
    assign BP_taken     = if_hit && ctr_q[if_idx][1];
    assign BP_target_pc = if_hit ? target_q[if_idx] : IF_pc + memAddrWidth'(4);

    assign upd     = E_En && !Stall_MA;
    assign exe_hit = valid_q[exe_idx] && (tag_q[exe_idx] == exe_tag);

    sat_counter2 u_ctr (
        .ctr_i (ctr_q[exe_idx]),
        .up_i  (E_Branch_taken),
        .ctr_o (ctr_next)
    );

    always_comb begin
        wr_en_d     = 1'b0;
        wr_ctr_d    = ctr_q[exe_idx];
        wr_target_d = target_q[exe_idx];
        if (upd) begin
            if (exe_hit) begin
                wr_en_d  = 1'b1;
                wr_ctr_d = ctr_next;
                if (E_Branch_taken) wr_target_d = EXE_target_pc;
            end else if (E_Branch_taken) begin
                // Allocation evicts whatever aliased into this slot.
                wr_en_d     = 1'b1;
                wr_ctr_d    = WT;
                wr_target_d = EXE_target_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (wr_en_d) begin
            valid_q[exe_idx]  <= 1'b1;
            tag_q[exe_idx]    <= exe_tag;
            target_q[exe_idx] <= wr_target_d;
            ctr_q[exe_idx]    <= wr_ctr_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized and directed self-checking bench for branch_predictor
module tb_branch_predictor;

    localparam int AW  = 15;
    localparam int NE  = 16;
    localparam int IW  = 4;
    localparam int MSK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] IF_pc = '0;
    logic          BP_taken;
    logic [AW-1:0] BP_target_pc;
    logic          BP_hit;
    logic [AW-1:0] EXE_pc = '0;
    logic          E_En = 1'b0;
    logic          E_Branch_taken = 1'b0;
    logic [AW-1:0] EXE_target_pc = '0;
    logic          Stall_MA = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    bit armed = 0;

    // Reference: one slot per index, direction strength as an integer 0..3.
    bit m_valid [NE];
    int m_tag   [NE];
    int m_tgt   [NE];
    int m_str   [NE];

    branch_predictor #(.memAddrWidth(AW), .ENTRIES(NE)) dut (
        .clk            (clk),
        .rst            (rst),
        .IF_pc          (IF_pc),
        .BP_taken       (BP_taken),
        .BP_target_pc   (BP_target_pc),
        .BP_hit         (BP_hit),
        .EXE_pc         (EXE_pc),
        .E_En           (E_En),
        .E_Branch_taken (E_Branch_taken),
        .EXE_target_pc  (EXE_target_pc),
        .Stall_MA       (Stall_MA)
    );

    always #5 clk = ~clk;

    function automatic int slot(input int pc);
        return (pc / 4) % NE;
    endfunction

    function automatic int tagof(input int pc);
        return pc / (4 * NE);
    endfunction

    function automatic bit exp_hit(input int pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
    endfunction

    function automatic bit exp_taken(input int pc);
        return exp_hit(pc) && (m_str[slot(pc)] >= 2);
    endfunction

    function automatic int exp_target(input int pc);
        return exp_hit(pc) ? m_tgt[slot(pc)] : ((pc + 4) & MSK);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (IF_pc=0x%0h t=%0t)", name, act, exp, IF_pc, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NE; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_str[i] = 1;
            end
        end else if (E_En && !Stall_MA) begin
            int p, s;
            p = int'(EXE_pc);
            s = slot(p);
            if (exp_hit(p)) begin
                if (E_Branch_taken) begin
                    m_str[s] = (m_str[s] == 3) ? 3 : m_str[s] + 1;
                    m_tgt[s] = int'(EXE_target_pc);
                end else begin
                    m_str[s] = (m_str[s] == 0) ? 0 : m_str[s] - 1;
                end
            end else if (E_Branch_taken) begin
                m_valid[s] = 1; m_tag[s] = tagof(p); m_tgt[s] = int'(EXE_target_pc); m_str[s] = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_hit",    32'(BP_hit),       32'(exp_hit(int'(IF_pc))));
            check("model_taken",  32'(BP_taken),     32'(exp_taken(int'(IF_pc))));
            check("model_target", 32'(BP_target_pc), 32'(exp_target(int'(IF_pc))));
        end
    end

    task automatic cyc(input int ifpc, input bit en, input bit tk, input int tgt, input int expc, input bit st);
        @(posedge clk);
        #1;
        IF_pc = AW'(ifpc); E_En = en; E_Branch_taken = tk;
        EXE_target_pc = AW'(tgt); EXE_pc = AW'(expc); Stall_MA = st;
        @(negedge clk);
        #1;
    endtask

    task automatic look(input int pc);
        cyc(pc, 0, 0, 0, 0, 0);
    endtask

    task automatic train(input int pc, input bit tk, input int tgt);
        cyc(pc, 1, tk, tgt, pc, 0);
    endtask

    initial begin
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_str[i] = 1;
        end
        #1 rst = 1'b1;
        armed = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        look(32'h40);
        check("reset_hit", 32'(BP_hit), 0);
        check("reset_target", 32'(BP_target_pc), 32'h44);

        // allocate and hit
        train(32'h40, 1, 32'h100);
        look(32'h40);
        check("alloc_hit", 32'(BP_hit), 1);
        check("alloc_taken", 32'(BP_taken), 1);
        check("alloc_target", 32'(BP_target_pc), 32'h100);
        look(32'h440);
        check("alias_miss", 32'(BP_hit), 0);

        // retarget on taken hit
        train(32'h40, 1, 32'h200);
        look(32'h40);
        check("retarget", 32'(BP_target_pc), 32'h200);

        // saturation
        repeat (3) train(32'h40, 1, 32'h200);
        train(32'h40, 0, 0);
        look(32'h40);
        check("st_minus1_taken", 32'(BP_taken), 1);
        train(32'h40, 0, 0);
        look(32'h40);
        check("wnt_taken", 32'(BP_taken), 0);
        repeat (3) train(32'h40, 0, 0);
        look(32'h40);
        check("snt_taken", 32'(BP_taken), 0);
        check("snt_valid", 32'(BP_hit), 1);
        check("snt_target_kept", 32'(BP_target_pc), 32'h200);

        // stall gating: stalled not-taken must not weaken a WT entry
        train(32'hC0, 1, 32'h300);
        repeat (5) cyc(32'hC0, 1, 0, 0, 32'hC0, 1);
        look(32'hC0);
        check("stall_nt_held", 32'(BP_taken), 1);
        train(32'hC0, 0, 0);
        look(32'hC0);
        check("stall_nt_release", 32'(BP_taken), 0);
        train(32'hC0, 1, 32'h300);
        repeat (5) cyc(32'hC0, 1, 1, 32'h300, 32'hC0, 1);
        train(32'hC0, 1, 32'h300);
        train(32'hC0, 0, 0);
        look(32'hC0);
        check("stall_t_st_minus1", 32'(BP_taken), 1);

        // same-cycle read/write: no bypass
        train(32'h80, 1, 32'h124);
        check("same_cycle_hit", 32'(BP_hit), 0);
        check("same_cycle_target", 32'(BP_target_pc), 32'h84);
        look(32'h80);
        check("next_cycle_hit", 32'(BP_hit), 1);
        check("next_cycle_target", 32'(BP_target_pc), 32'h124);

        // wrap of the fall-through target
        look(32'h7FFC);
        check("wrap_target", 32'(BP_target_pc), 0);

        // randomized traffic over a small PC pool so aliasing and hits are frequent
        for (int n = 0; n < 3000; n++) begin
            int ep, ip;
            ep = int'(($urandom & 32'hFC) | ($urandom_range(0, 1) << 10) | $urandom_range(0, 3));
            ip = ($urandom_range(0, 3) == 0) ? ep
                 : int'(($urandom & 32'hFC) | ($urandom_range(0, 1) << 10) | $urandom_range(0, 3));
            if (n % 16 == 0) ip = int'($urandom & MSK);
            cyc(ip, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                int'($urandom & MSK), ep, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end

        // mid-run reset with a pending update, then sweep
        @(posedge clk);
        #1;
        E_En = 1; E_Branch_taken = 1; EXE_pc = AW'(32'h40); Stall_MA = 0;
        rst = 1'b1;
        for (int pc = 0; pc <= 32'h3C; pc += 4) begin
            if (pc < 16) begin
                cyc(pc, 1, 1, 32'h55C, pc, 0);
            end else begin
                if (pc == 16) rst = 1'b0;
                look(pc);
            end
            check("rst_sweep_hit", 32'(BP_hit), 0);
            check("rst_sweep_taken", 32'(BP_taken), 0);
            check("rst_sweep_target", 32'(BP_target_pc), 32'(pc + 4));
        end

        armed = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
